// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder processing one digit per clock, LSD first, with a
// start/busy/done handshake, registered result and active-low 7-segment outputs.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// ADD   | one BCD digit summed per cycle, operands shifted right
// DONE  | result, carry and error flag copied to the output registers
module bcd_serial_adder #(
  parameter int DIGITS        = 4,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      start,
  input  logic [4*DIGITS-1:0]       A,
  input  logic [4*DIGITS-1:0]       B,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [4*DIGITS-1:0]       sum,
  output logic                      cout,
  output logic                      err,
  output logic [7*(DIGITS+1)-1:0]   HEX
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_work;
  logic [W-1:0]   b_work;
  logic [W-1:0]   res_work;
  logic           carry;
  logic           err_acc;
  logic [3:0]     idx;

  logic [4:0]     dsum;
  logic [3:0]     digit;
  logic           carry_nxt;
  logic           digit_bad;
  logic [W+3:0]   res_shift;

  // Operands shift right each cycle so the active digit is always at [3:0];
  // the result shifts in from the top so it lands in place after DIGITS cycles.
  always_comb begin
    dsum      = {1'b0, a_work[3:0]} + {1'b0, b_work[3:0]} + {4'd0, carry};
    digit     = dsum[3:0];
    carry_nxt = 1'b0;
    if (dsum > 5'd9) begin
      digit     = dsum[3:0] + 4'd6;
      carry_nxt = 1'b1;
    end
    digit_bad = (a_work[3:0] > 4'd9) || (b_work[3:0] > 4'd9);
    res_shift = {digit, res_work};
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      a_work   <= '0;
      b_work   <= '0;
      res_work <= '0;
      carry    <= 1'b0;
      err_acc  <= 1'b0;
      idx      <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            a_work   <= A;
            b_work   <= B;
            carry    <= cin;
            res_work <= '0;
            err_acc  <= 1'b0;
            idx      <= 4'd0;
            state    <= ADD;
          end
        end
        ADD: begin
          a_work   <= a_work >> 4;
          b_work   <= b_work >> 4;
          res_work <= res_shift[W+3:4];
          carry    <= carry_nxt;
          err_acc  <= err_acc | digit_bad;
          idx      <= idx + 4'd1;
          if (idx == 4'(DIGITS - 1)) state <= DONE;
        end
        DONE: begin
          sum   <= res_work;
          cout  <= carry;
          err   <= err_acc;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  logic any_nz;

  // Scan from the top digit down; a digit is blank until a nonzero one is seen.
  always_comb begin
    any_nz = 1'b0;
    HEX    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz = any_nz | (sum[4*i +: 4] != 4'd0);
      if (BLANK_LEADING && (i != 0) && !any_nz)
        HEX[7*i +: 7] = 7'b1111111;
      else
        HEX[7*i +: 7] = seg(sum[4*i +: 4]);
    end
    if (cout)
      HEX[7*DIGITS +: 7] = 7'b1111001;
    else if (BLANK_LEADING)
      HEX[7*DIGITS +: 7] = 7'b1111111;
    else
      HEX[7*DIGITS +: 7] = 7'b1000000;
  end

endmodule
